axi_cmd_master: RTL and testbench
=================================

// Module: axi_cmd_master
// PURPOSE
//  Single-outstanding AXI initiator driven by a simple command port. It issues one INCR burst,
//  write or read, per command, then reports completion status.
//  Sits opposite the decode-error default slave and real slaves on the AXI fabric.
//  Used as the bus-test and bring-up master.
//  Write data comes from an incrementing pattern; read data is forwarded beat by beat.
// PARAMETERS
//  W_CID   4         channel ID width
//  W_ID    4         ID width
//  W_ADDR  32        address width
//  W_DATA  32        data width
//  W_STRB  W_DATA/8  strobe width
//  W_SID   W_CID+W_ID  full ID width
// PORTS
//  AXI_CLK      in   1       clock; all logic on rising edge
//  AXI_RST      in   1       synchronous, active-high reset
//  CMD_VALID    in   1       command request
//  CMD_READY    out  1       command accepted when VALID&READY
//  CMD_WRITE    in   1       1=write burst, 0=read burst
//  CMD_ID       in   W_SID   transaction ID
//  CMD_ADDR     in   W_ADDR  start address
//  CMD_LEN      in   8       beats-1
//  CMD_SEED     in   W_DATA  first write-data word / expected first read word
//  RD_DATA      out  W_DATA  read beat data
//  RD_VALID     out  1       one-cycle pulse per accepted R beat
//  DONE         out  1       one-cycle completion pulse
//  DONE_RESP    out  2       max BRESP/RRESP seen in the burst
//  DONE_ERR     out  1       protocol error in the burst (ID or RLAST mismatch)
//  ERR_CNT      out  16      read-data mismatch count (RCHK only)
//  AW*/W*/B*/AR*/R*  AXI master side; signal set and widths mirror the slave (AWID..RREADY, incl. WID)
// BEHAVIOUR
//  Reset (sync, AXI_RST=1 at edge):
//   - all VALID/READY outputs, DONE, DONE_ERR, RD_VALID, DONE_RESP and ERR_CNT go to 0.
//   - address, ID and data outputs go to 0; state goes to IDLE.
//   - a burst in flight is abandoned and never resumed.
//  FSM states and transitions:
//   - IDLE: CMD_READY=1. On accept, latch the command; go to AW (write) or AR (read).
//   - AW: AWVALID=1; AWID/AWADDR/AWLEN driven from the latch.
//     AWSIZE=log2(W_STRB); AWBURST=2'b01.
//     All stay stable until AWREADY; then go to W.
//   - W: WVALID=1, WSTRB all ones, WID=latched ID.
//     WDATA=seed+beat (mod 2^W_DATA); WLAST=(beat==LEN).
//     beat increments on WREADY. On the last handshake go to B.
//     No W is issued before the AW handshake.
//   - B: BREADY=1. On BVALID: DONE_RESP=BRESP; DONE_ERR=(BID!=ID); go to DONE.
//   - AR: ARVALID=1 with the same field rules as AW, until ARREADY; then go to R.
//   - R: RREADY=1. Each RVALID beat:
//     - RD_VALID=1 and RD_DATA=RDATA in the next cycle;
//     - resp accumulator = max(acc, RRESP);
//     - DONE_ERR set on RID!=ID, RLAST at beat<LEN, or no RLAST at beat==LEN.
//     Leave on an RLAST beat or on beat==LEN, whichever comes first.
//   - DONE: DONE=1 for exactly one cycle; return to IDLE.
//     CMD_READY is 0 here, so the minimum inter-command gap is 1 cycle.
//  Beat counter is 9 bits, so LEN=255 gives 256 beats with no wrap.
//  Simultaneous CMD_VALID during a busy burst: ignored (CMD_READY=0).
//  A slave that drops READY never causes a VALID to deassert or a payload to change.
//  Latency with an always-ready slave:
//   - write: accept -> AWVALID +1 cycle; first WVALID at AW handshake +1; DONE at B handshake +1.
//   - read: DONE at last R beat +1.
// CONFIGURATION
//  AXI_CMD_MASTER_RCHK_EN defined:
//   - each R beat is compared with seed+beat;
//   - ERR_CNT increments on mismatch, saturating at 16'hFFFF;
//   - ERR_CNT is cleared on command accept and on reset.
//  Undefined: no comparator; ERR_CNT tied to 0.
// TESTING
//  1. Write, ADDR=0x100, LEN=3, SEED=0x10, default slave (DECERR):
//     -> WDATA 0x10..0x13, WLAST on beat 4 only, DONE_RESP=2'b11, DONE_ERR=0.
//  2. Read, LEN=0, ID=0x25, default slave:
//     -> one RD_VALID with RD_DATA=0xFFFFFFFF, DONE_RESP=3, DONE_ERR=0.
//  3. Slave holds AWREADY low for 5 cycles:
//     -> AWVALID=1 and AWADDR/AWLEN/AWID constant for all 5; WVALID=0 until the handshake.
//  4. Read LEN=7, memory slave inserts RVALID gaps, returns RLAST on beat 4:
//     -> 4 RD_VALID pulses, DONE_ERR=1, DONE after beat 4.
//  5. Assert AXI_RST mid-write (beat 2 of 8):
//     -> next cycle all VALIDs=0, CMD_READY=1 after release, and a new command completes normally.
//  6. RCHK_EN, read LEN=3, SEED=0, slave returns 0,1,9,3:
//     -> ERR_CNT=1; without the macro ERR_CNT=0.

Source files
------------

// File: rtl/axi_cmd_master.sv
// axi_cmd_master: single-outstanding AXI initiator issuing one INCR write or read burst per command.
// Optional read-data checker: define AXI_CMD_MASTER_RCHK_EN to enable the ERR_CNT comparator.
module axi_cmd_master #(
   parameter int unsigned W_CID  = 4,
   parameter int unsigned W_ID   = 4,
   parameter int unsigned W_ADDR = 32,
   parameter int unsigned W_DATA = 32,
   parameter int unsigned W_STRB = W_DATA / 8,
   parameter int unsigned W_SID  = W_CID + W_ID
) (
   input  logic              AXI_CLK,
   input  logic              AXI_RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [W_SID-1:0]  CMD_ID,
   input  logic [W_ADDR-1:0] CMD_ADDR,
   input  logic [7:0]        CMD_LEN,
   input  logic [W_DATA-1:0] CMD_SEED,
   output logic [W_DATA-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic              DONE,
   output logic [1:0]        DONE_RESP,
   output logic              DONE_ERR,
   output logic [15:0]       ERR_CNT,
   output logic [W_SID-1:0]  AWID,
   output logic [W_ADDR-1:0] AWADDR,
   output logic [7:0]        AWLEN,
   output logic [2:0]        AWSIZE,
   output logic [1:0]        AWBURST,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [W_SID-1:0]  WID,
   output logic [W_DATA-1:0] WDATA,
   output logic [W_STRB-1:0] WSTRB,
   output logic              WLAST,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic [W_SID-1:0]  BID,
   input  logic [1:0]        BRESP,
   input  logic              BVALID,
   output logic              BREADY,
   output logic [W_SID-1:0]  ARID,
   output logic [W_ADDR-1:0] ARADDR,
   output logic [7:0]        ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [W_SID-1:0]  RID,
   input  logic [W_DATA-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY
);

   localparam logic [2:0] AxSize = 3'($clog2(W_STRB));

   typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

   state_e             state_q, state_d;
   logic [W_SID-1:0]   id_q;
   logic [W_ADDR-1:0]  addr_q;
   logic [7:0]         len_q;
   logic [W_DATA-1:0]  seed_q;
   logic [8:0]         beat_q;
   logic [1:0]         resp_q;
   logic               err_q;
   logic [W_DATA-1:0]  rd_data_q;
   logic               rd_valid_q;
   logic               cmd_hs, w_hs, b_hs, r_hs, beat_last;
   logic [W_DATA-1:0]  beat_data;

   assign cmd_hs    = (state_q == StIdle) && CMD_VALID;
   assign w_hs      = WVALID && WREADY;
   assign b_hs      = BVALID && BREADY;
   assign r_hs      = RVALID && RREADY;
   assign beat_last = (beat_q == {1'b0, len_q});
   assign beat_data = seed_q + W_DATA'(beat_q);

   always_ff @(posedge AXI_CLK) begin
      if (AXI_RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (CMD_VALID) state_d = CMD_WRITE ? StAw : StAr;
         StAw:    if (AWREADY) state_d = StW;
         StW:     if (WREADY && beat_last) state_d = StB;
         StB:     if (BVALID) state_d = StDone;
         StAr:    if (ARREADY) state_d = StR;
         StR:     if (RVALID && (RLAST || beat_last)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // CMD_READY is held low while reset is asserted even though the state is already idle.
   always_comb begin
      CMD_READY = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      DONE      = 1'b0;
      unique case (state_q)
         StIdle:  CMD_READY = !AXI_RST;
         StAw:    AWVALID = 1'b1;
         StW:     WVALID = 1'b1;
         StB:     BREADY = 1'b1;
         StAr:    ARVALID = 1'b1;
         StR:     RREADY = 1'b1;
         StDone:  DONE = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge AXI_CLK) begin
      if (AXI_RST) begin
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         seed_q     <= '0;
         beat_q     <= '0;
         resp_q     <= '0;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         if (cmd_hs) begin
            id_q   <= CMD_ID;
            addr_q <= CMD_ADDR;
            len_q  <= CMD_LEN;
            seed_q <= CMD_SEED;
            beat_q <= '0;
            resp_q <= '0;
            err_q  <= 1'b0;
         end
         if (w_hs) beat_q <= beat_q + 9'd1;
         if (b_hs) begin
            resp_q <= BRESP;
            err_q  <= (BID != id_q);
         end
         if (r_hs) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= RDATA;
            beat_q     <= beat_q + 9'd1;
            if (RRESP > resp_q) resp_q <= RRESP;
            if ((RID != id_q) || (RLAST != beat_last)) err_q <= 1'b1;
         end
      end
   end

`ifdef AXI_CMD_MASTER_RCHK_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge AXI_CLK) begin
      if (AXI_RST || cmd_hs) begin
         err_cnt_q <= '0;
      end else if (r_hs && (RDATA != beat_data) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign ERR_CNT = err_cnt_q;
`else
   assign ERR_CNT = '0;
`endif

   assign AWID      = id_q;
   assign AWADDR    = addr_q;
   assign AWLEN     = len_q;
   assign AWSIZE    = AxSize;
   assign AWBURST   = 2'b01;
   assign ARID      = id_q;
   assign ARADDR    = addr_q;
   assign ARLEN     = len_q;
   assign ARSIZE    = AxSize;
   assign ARBURST   = 2'b01;
   assign WID       = id_q;
   assign WDATA     = beat_data;
   assign WSTRB     = '1;
   assign WLAST     = (state_q == StW) && beat_last;
   assign RD_DATA   = rd_data_q;
   assign RD_VALID  = rd_valid_q;
   assign DONE_RESP = resp_q;
   assign DONE_ERR  = err_q;

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master with a behavioural AXI slave driven on the falling clock edge.
`timescale 1ns/1ps
module tb_axi_cmd_master;

   logic        AXI_CLK = 1'b0;
   logic        AXI_RST = 1'b1;
   logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
   logic [7:0]  CMD_ID = '0, CMD_LEN = '0;
   logic [31:0] CMD_ADDR = '0, CMD_SEED = '0;
   logic [31:0] RD_DATA;
   logic        RD_VALID, DONE, DONE_ERR;
   logic [1:0]  DONE_RESP;
   logic [15:0] ERR_CNT;
   logic [7:0]  AWID, AWLEN, WID, ARID, ARLEN;
   logic [31:0] AWADDR, ARADDR, WDATA;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST;
   logic [3:0]  WSTRB;
   logic        AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
   logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0;
   logic        RVALID = 1'b0, RLAST = 1'b0;
   logic [7:0]  BID = '0, RID = '0;
   logic [1:0]  BRESP = '0, RRESP = '0;
   logic [31:0] RDATA = '0;

   int total = 0;
   int bad   = 0;

   always #5 AXI_CLK = ~AXI_CLK;

   axi_cmd_master dut (
      .AXI_CLK(AXI_CLK), .AXI_RST(AXI_RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE), .CMD_ID(CMD_ID),
      .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_SEED(CMD_SEED),
      .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .DONE(DONE), .DONE_RESP(DONE_RESP),
      .DONE_ERR(DONE_ERR), .ERR_CNT(ERR_CNT),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   // Slave knobs, set by the test tasks.
   int          aw_delay   = 0;
   logic [1:0]  s_bresp    = 2'b11;
   logic        s_bid_flip = 1'b0;
   logic        s_rgap     = 1'b0;
   int          s_rlast    = 0;
   logic [31:0] s_rdata [16];
   logic [1:0]  s_rresp [16];

   initial begin : slave
      int aw_cnt = 0;
      int r_idx = 0;
      int r_phase = 0;
      logic [7:0] aw_id_s = '0;
      logic [7:0] ar_id_s = '0;
      forever begin
         @(negedge AXI_CLK);
         if (AXI_RST) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
            aw_cnt = 0; r_idx = 0; r_phase = 0;
         end else begin
            if (!AWVALID) begin
               AWREADY = 0; aw_cnt = 0;
            end else if (aw_cnt >= aw_delay) begin
               AWREADY = 1; aw_id_s = AWID;
            end else begin
               AWREADY = 0; aw_cnt++;
            end
            ARREADY = ARVALID;
            if (ARVALID) ar_id_s = ARID;
            WREADY = WVALID;
            BVALID = BREADY;
            BID    = s_bid_flip ? ~aw_id_s : aw_id_s;
            BRESP  = s_bresp;
            if (RREADY) begin
               r_phase++;
               if (s_rgap && (r_phase % 2) == 0) begin
                  RVALID = 0;
               end else begin
                  RVALID = 1;
                  RDATA  = s_rdata[r_idx % 16];
                  RRESP  = s_rresp[r_idx % 16];
                  RLAST  = (r_idx == s_rlast);
                  RID    = ar_id_s;
                  r_idx++;
               end
            end else begin
               RVALID = 0; RLAST = 0; r_idx = 0; r_phase = 0;
            end
         end
      end
   end

   // Observations gathered by run_burst.
   int          mon_nw, mon_nrd, mon_done_cyc, mon_rd_last_cyc, mon_aw_wait;
   logic        mon_first_ax, mon_aw_unstable, mon_w_early, mon_done_seen, mon_err;
   logic [1:0]  mon_resp;
   logic [15:0] mon_errcnt;
   logic [31:0] mon_w [16];
   logic        mon_wl [16];
   logic [31:0] mon_rd [16];
   logic [3:0]  mon_wstrb;
   logic [7:0]  mon_wid;
   logic [52:0] mon_ar;

   task automatic do_cmd(input logic wr, input logic [7:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [31:0] seed, output logic acc);
      int n = 0;
      @(negedge AXI_CLK);
      CMD_WRITE = wr; CMD_ID = id; CMD_ADDR = addr; CMD_LEN = len; CMD_SEED = seed;
      CMD_VALID = 1'b1;
      #1;
      while (!CMD_READY && n < 50) begin
         @(negedge AXI_CLK); #1; n++;
      end
      acc = CMD_READY;
      @(negedge AXI_CLK);
      CMD_VALID = 1'b0;
   endtask

   task automatic run_burst(input int budget);
      logic aw_seen = 0, aw_hs = 0;
      logic [47:0] aw_snap = '0;
      mon_nw = 0; mon_nrd = 0; mon_done_cyc = -1; mon_rd_last_cyc = -2; mon_aw_wait = 0;
      mon_aw_unstable = 0; mon_w_early = 0; mon_done_seen = 0; mon_first_ax = 0;
      mon_err = 1'bx; mon_resp = 2'bxx; mon_errcnt = 'x; mon_wstrb = 'x; mon_wid = 'x;
      mon_ar = 'x;
      for (int c = 0; c < budget && !mon_done_seen; c++) begin
         #1;
         if (c == 0) mon_first_ax = AWVALID || ARVALID;
         if (AWVALID) begin
            if (!aw_seen) begin
               aw_snap = {AWID, AWLEN, AWADDR}; aw_seen = 1;
            end else if ({AWID, AWLEN, AWADDR} !== aw_snap) begin
               mon_aw_unstable = 1;
            end
            if (!AWREADY) mon_aw_wait++;
         end
         if (ARVALID) mon_ar = {ARID, ARLEN, ARADDR, ARSIZE, ARBURST};
         if (WVALID && !aw_hs) mon_w_early = 1;
         if (AWVALID && AWREADY) aw_hs = 1;
         if (WVALID && WREADY && mon_nw < 16) begin
            mon_w[mon_nw] = WDATA; mon_wl[mon_nw] = WLAST; mon_nw++;
            mon_wstrb = WSTRB; mon_wid = WID;
         end
         if (RD_VALID && mon_nrd < 16) begin
            mon_rd[mon_nrd] = RD_DATA; mon_nrd++; mon_rd_last_cyc = c;
         end
         if (DONE) begin
            mon_done_seen = 1; mon_done_cyc = c;
            mon_resp = DONE_RESP; mon_err = DONE_ERR; mon_errcnt = ERR_CNT;
         end
         @(negedge AXI_CLK);
      end
   endtask

   task automatic test_reset;
      AXI_RST = 1'b1;
      repeat (3) @(negedge AXI_CLK);
      #1;
      total++;
      if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, CMD_READY, DONE, RD_VALID, DONE_ERR}
          !== 9'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b want=0", {AWVALID, WVALID, BREADY, ARVALID,
                         RREADY, CMD_READY, DONE, RD_VALID, DONE_ERR});
      end
      total++;
      if ({DONE_RESP, ERR_CNT} !== 18'h0) begin
         bad++; $display("FAIL reset_status got=%h/%h want=0/0", DONE_RESP, ERR_CNT);
      end
      total++;
      if ({AWADDR, ARADDR, AWID, WDATA} !== 104'h0) begin
         bad++; $display("FAIL reset_payload addr=%h id=%h wdata=%h want=0", AWADDR, AWID, WDATA);
      end
      AXI_RST = 1'b0;
      @(negedge AXI_CLK); #1;
      total++;
      if (CMD_READY !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready got=%b want=1", CMD_READY);
      end
   endtask

   task automatic test_write_decerr;
      logic acc;
      s_bresp = 2'b11;
      do_cmd(1'b1, 8'h13, 32'h100, 8'd3, 32'h10, acc);
      run_burst(100);
      total++;
      if (acc !== 1'b1 || mon_first_ax !== 1'b1) begin
         bad++; $display("FAIL wr_accept acc=%b awvalid=%b want=1/1", acc, mon_first_ax);
      end
      total++;
      if (mon_nw !== 4) begin
         bad++; $display("FAIL wr_beats got=%0d want=4", mon_nw);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mon_w[i] !== 32'h10 + i || mon_wl[i] !== (i == 3)) begin
            bad++; $display("FAIL wr_beat%0d got=%h/%b want=%h/%b", i, mon_w[i], mon_wl[i],
                            32'h10 + i, (i == 3));
         end
      end
      total++;
      if (mon_wstrb !== 4'hF || mon_wid !== 8'h13) begin
         bad++; $display("FAIL wr_strb_id got=%h/%h want=f/13", mon_wstrb, mon_wid);
      end
      total++;
      if (mon_done_cyc !== 6 || mon_resp !== 2'b11 || mon_err !== 1'b0) begin
         bad++; $display("FAIL wr_done cyc=%0d resp=%b err=%b want=6/11/0", mon_done_cyc,
                         mon_resp, mon_err);
      end
   endtask

   task automatic test_read_decerr;
      logic acc;
      s_rgap = 0; s_rlast = 0; s_rdata[0] = 32'hFFFF_FFFF; s_rresp[0] = 2'b11;
      do_cmd(1'b0, 8'h25, 32'h200, 8'd0, 32'h0, acc);
      run_burst(100);
      total++;
      if (acc !== 1'b1 || mon_ar !== {8'h25, 8'h00, 32'h200, 3'd2, 2'b01}) begin
         bad++; $display("FAIL rd_ar acc=%b ar=%h want=1/%h", acc, mon_ar,
                         {8'h25, 8'h00, 32'h200, 3'd2, 2'b01});
      end
      total++;
      if (mon_nrd !== 1 || mon_rd[0] !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL rd_data n=%0d d=%h want=1/ffffffff", mon_nrd, mon_rd[0]);
      end
      total++;
      if (mon_done_cyc !== 2 || mon_resp !== 2'b11 || mon_err !== 1'b0) begin
         bad++; $display("FAIL rd_done cyc=%0d resp=%b err=%b want=2/11/0", mon_done_cyc,
                         mon_resp, mon_err);
      end
   endtask

   task automatic test_aw_stall;
      logic acc;
      aw_delay = 5; s_bresp = 2'b00;
      do_cmd(1'b1, 8'h3A, 32'h4000, 8'd1, 32'hA0, acc);
      #1;
      total++;
      if ({AWVALID, AWSIZE, AWBURST, AWID, AWLEN, AWADDR} !==
          {1'b1, 3'd2, 2'b01, 8'h3A, 8'd1, 32'h4000}) begin
         bad++; $display("FAIL aw_fields got=%b/%0d/%b/%h/%h/%h", AWVALID, AWSIZE, AWBURST, AWID,
                         AWLEN, AWADDR);
      end
      run_burst(100);
      aw_delay = 0;
      total++;
      if (mon_aw_wait !== 5 || mon_aw_unstable !== 1'b0 || mon_w_early !== 1'b0) begin
         bad++; $display("FAIL aw_stall wait=%0d unstable=%b early_w=%b want=5/0/0",
                         mon_aw_wait, mon_aw_unstable, mon_w_early);
      end
      total++;
      if (mon_nw !== 2 || mon_w[1] !== 32'hA1 || mon_done_cyc !== 9 || mon_resp !== 2'b00) begin
         bad++; $display("FAIL aw_stall_done n=%0d w1=%h cyc=%0d resp=%b want=2/a1/9/00",
                         mon_nw, mon_w[1], mon_done_cyc, mon_resp);
      end
   endtask

   task automatic test_read_early_rlast;
      logic acc;
      s_rgap = 1; s_rlast = 3;
      for (int i = 0; i < 8; i++) begin
         s_rdata[i] = 32'h1000 + i; s_rresp[i] = 2'b00;
      end
      s_rresp[1] = 2'b10; s_rresp[2] = 2'b01;
      do_cmd(1'b0, 8'h41, 32'h300, 8'd7, 32'h1000, acc);
      run_burst(200);
      s_rgap = 0;
      total++;
      if (acc !== 1'b1 || mon_nrd !== 4) begin
         bad++; $display("FAIL rlast_pulses acc=%b n=%0d want=1/4", acc, mon_nrd);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mon_rd[i] !== 32'h1000 + i) begin
            bad++; $display("FAIL rlast_data%0d got=%h want=%h", i, mon_rd[i], 32'h1000 + i);
         end
      end
      total++;
      if (mon_err !== 1'b1 || mon_resp !== 2'b10 || mon_errcnt !== 16'd0) begin
         bad++; $display("FAIL rlast_status err=%b resp=%b cnt=%0d want=1/10/0", mon_err,
                         mon_resp, mon_errcnt);
      end
      total++;
      if (mon_done_cyc !== 8 || mon_rd_last_cyc !== mon_done_cyc) begin
         bad++; $display("FAIL rlast_done cyc=%0d last_rd=%0d want=8/8", mon_done_cyc,
                         mon_rd_last_cyc);
      end
   endtask

   task automatic test_bid_mismatch;
      logic acc;
      s_bid_flip = 1; s_bresp = 2'b01;
      do_cmd(1'b1, 8'h5C, 32'h500, 8'd0, 32'h0, acc);
      run_burst(100);
      s_bid_flip = 0;
      total++;
      if (acc !== 1'b1 || mon_err !== 1'b1 || mon_resp !== 2'b01 || mon_wl[0] !== 1'b1) begin
         bad++; $display("FAIL bid_err acc=%b err=%b resp=%b wlast=%b want=1/1/01/1", acc,
                         mon_err, mon_resp, mon_wl[0]);
      end
   endtask

   task automatic test_reset_mid_write;
      logic acc;
      int n = 0;
      int c = 0;
      s_bresp = 2'b01;
      do_cmd(1'b1, 8'h07, 32'h800, 8'd7, 32'h50, acc);
      while (n < 2 && c < 100) begin
         #1;
         if (WVALID && WREADY) n++;
         @(negedge AXI_CLK);
         c++;
      end
      #1;
      AXI_RST = 1'b1;
      @(negedge AXI_CLK); #1;
      total++;
      if (n !== 2 || {AWVALID, WVALID, BREADY, ARVALID, RREADY, DONE, RD_VALID} !== 7'b0) begin
         bad++; $display("FAIL midrst_valids beats=%0d got=%b want=2/0", n, {AWVALID, WVALID,
                         BREADY, ARVALID, RREADY, DONE, RD_VALID});
      end
      total++;
      if ({WDATA, AWADDR, DONE_RESP} !== 66'h0) begin
         bad++; $display("FAIL midrst_payload wdata=%h addr=%h resp=%b want=0", WDATA, AWADDR,
                         DONE_RESP);
      end
      AXI_RST = 1'b0;
      @(negedge AXI_CLK); #1;
      total++;
      if (CMD_READY !== 1'b1) begin
         bad++; $display("FAIL midrst_ready got=%b want=1", CMD_READY);
      end
      do_cmd(1'b1, 8'h08, 32'h900, 8'd1, 32'h60, acc);
      run_burst(100);
      total++;
      if (acc !== 1'b1 || mon_nw !== 2 || mon_w[0] !== 32'h60 || mon_w[1] !== 32'h61) begin
         bad++; $display("FAIL midrst_new acc=%b n=%0d w=%h,%h want=1/2/60,61", acc, mon_nw,
                         mon_w[0], mon_w[1]);
      end
      total++;
      if (mon_done_seen !== 1'b1 || mon_resp !== 2'b01 || mon_err !== 1'b0) begin
         bad++; $display("FAIL midrst_done seen=%b resp=%b err=%b want=1/01/0", mon_done_seen,
                         mon_resp, mon_err);
      end
   endtask

   task automatic test_rchk;
      logic acc;
      logic [15:0] exp_cnt;
`ifdef AXI_CMD_MASTER_RCHK_EN
      exp_cnt = 16'd1;
`else
      exp_cnt = 16'd0;
`endif
      s_rlast = 3;
      s_rdata[0] = 32'd0; s_rdata[1] = 32'd1; s_rdata[2] = 32'd9; s_rdata[3] = 32'd3;
      for (int i = 0; i < 4; i++) s_rresp[i] = 2'b00;
      do_cmd(1'b0, 8'h11, 32'h400, 8'd3, 32'h0, acc);
      run_burst(100);
      total++;
      if (acc !== 1'b1 || mon_errcnt !== exp_cnt || mon_err !== 1'b0) begin
         bad++; $display("FAIL rchk_cnt acc=%b cnt=%0d err=%b want=1/%0d/0", acc, mon_errcnt,
                         mon_err, exp_cnt);
      end
      total++;
      if (mon_nrd !== 4 || mon_rd[2] !== 32'd9) begin
         bad++; $display("FAIL rchk_data n=%0d d2=%h want=4/9", mon_nrd, mon_rd[2]);
      end
      s_rlast = 0; s_rdata[0] = 32'h77;
      do_cmd(1'b0, 8'h12, 32'h404, 8'd0, 32'h77, acc);
      run_burst(100);
      total++;
      if (acc !== 1'b1 || mon_errcnt !== 16'd0 || mon_done_seen !== 1'b1) begin
         bad++; $display("FAIL rchk_clear acc=%b cnt=%0d done=%b want=1/0/1", acc, mon_errcnt,
                         mon_done_seen);
      end
   endtask

   initial begin
      test_reset();
      test_write_decerr();
      test_read_decerr();
      test_aw_stall();
      test_read_early_rlast();
      test_bid_mismatch();
      test_reset_mid_write();
      test_rchk();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t limit=200000", $time);
      $fatal(1);
   end

endmodule
